// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's load/store data-memory interface. It accepts one
// request at a time, holds a word-organised RAM and applies the RV32I load and
// store width/sign rules. The response comes back after WAIT_CYCLES wait states.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clock edge where valid && ready are both 1.
//   Once valid is raised, the payload stays stable and valid stays high until
//   that transfer edge. The responder raises req_ready only in IDLE. The
//   requester may hold rsp_ready low for any number of cycles.
//
// Parameters:
//   ADDR_W      byte-address width; the word index is req_addr[ADDR_W-1:2]
//   DEPTH       words of storage, equal to 2**(ADDR_W-2)
//   WAIT_CYCLES wait states between request accept and response (0 allowed)
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-low reset
//   req_valid/req_ready                   request handshake
//   req_write, req_addr, req_wdata, req_funct3   request payload
//   rsp_valid/rsp_ready                   response handshake
//   rsp_rdata, rsp_err                    response payload
//   dbg_state     current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Build option:
//   DMEM_MISALIGN_ERR_EN  when defined, a misaligned half or word access is
//                         rejected with rsp_err. When undefined, the access
//                         is forced to the enclosing aligned half or word.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;

    logic               l_write;
    logic [ADDR_W-1:0]  l_addr;
    logic [31:0]        l_wdata;
    logic [2:0]         l_funct3;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               do_access;
    logic               rsp_hs;

    logic [ADDR_W-3:0]  widx;
    logic [31:0]        word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic               legal;
    logic               misaligned;
    logic               reject;
    logic [31:0]        acc_rdata;
    logic               acc_err;
    logic               acc_we;
    logic [3:0]         acc_be;
    logic [31:0]        acc_wdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    // The first cycle in RESP (rsp_valid still low) is the single access cycle.
    assign do_access = (state == RESP) && !rsp_valid;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign dbg_state = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait-state counter: runs 0..WAIT_CYCLES-1 while in WAIT, else parked at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == WAIT && cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_write  <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_funct3 <= '0;
        end else if (accept) begin
            l_write  <= req_write;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
            l_funct3 <= req_funct3;
        end
    end

    // ---------------- access decode ----------------
    assign widx     = l_addr[ADDR_W-1:2];
    assign word     = mem[widx];
    assign byte_sel = word[{l_addr[1:0], 3'b000} +: 8];
    // Using only addr[1] for the half lane is what force-aligns a half access.
    assign half_sel = word[{l_addr[1], 4'b0000} +: 16];

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        reject     = 1'b0;
        acc_rdata  = '0;
        acc_err    = 1'b0;
        acc_we     = 1'b0;
        acc_be     = '0;
        acc_wdata  = '0;

        if (l_write) begin
            legal = (l_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            legal = (l_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned = ((l_funct3[1:0] == 2'b01) && l_addr[0]) ||
                     ((l_funct3[1:0] == 2'b10) && (l_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_ERR_EN
        reject = !legal || misaligned;
`else
        reject = !legal;
`endif

        if (reject) begin
            acc_err = 1'b1;
        end else if (l_write) begin
            acc_we = 1'b1;
            case (l_funct3[1:0])
                2'b00: begin
                    acc_be    = 4'b0001 << l_addr[1:0];
                    acc_wdata = {4{l_wdata[7:0]}};
                end
                2'b01: begin
                    acc_be    = l_addr[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{l_wdata[15:0]}};
                end
                default: begin
                    acc_be    = 4'b1111;
                    acc_wdata = l_wdata;
                end
            endcase
        end else begin
            case (l_funct3)
                3'b000:  acc_rdata = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  acc_rdata = {{16{half_sel[15]}}, half_sel};
                3'b010:  acc_rdata = word;
                3'b100:  acc_rdata = {24'd0, byte_sel};
                3'b101:  acc_rdata = {16'd0, half_sel};
                default: acc_rdata = '0;
            endcase
        end
    end

    // ---------------- RAM (not reset) ----------------
    always_ff @(posedge clk) begin
        if (do_access && acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[widx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (do_access) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= acc_err;
        end else if (rsp_hs) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Bench for dmem_responder with its default parameters. It runs a directed
// vector table, a reset-abort sequence and random traffic checked against a
// byte-addressed reference memory. Inputs are driven and outputs sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ADDR_W      = 8;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 1;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];          // {err, rdata} per outstanding request
    logic [7:0]  mem_m [256];       // reference memory, one entry per byte

    dmem_responder #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour: RV32I width/sign rules on a byte array.
    task automatic model_access(input logic wr, input logic [7:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [32:0] res);
        int size;
        bit sgn;
        bit legal;
        int base;
        logic [31:0] val;
        size = 4; sgn = 0; legal = 0; val = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; legal = 1; end
            3'd1: begin size = 2; sgn = 1; legal = 1; end
            3'd2: begin size = 4; legal = 1; end
            3'd4: begin size = 1; legal = !wr; end
            3'd5: begin size = 2; legal = !wr; end
            default: legal = 0;
        endcase
        res = {1'b1, 32'd0};
        if (!legal) return;
`ifdef DMEM_MISALIGN_ERR_EN
        if ((int'(addr) % size) != 0) return;
`endif
        base = int'(addr) - (int'(addr) % size);
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) val[8*i +: 8] = mem_m[base + i];
            if (sgn && size == 1) val = {{24{val[7]}}, val[7:0]};
            if (sgn && size == 2) val = {{16{val[15]}}, val[15:0]};
        end
        res = {1'b0, val};
    endtask

    // ---------------- driver ----------------
    // One complete transaction; hold = cycles of response backpressure.
    task automatic send(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [32:0] exp, input int hold);
        int n;
        int k;
        logic [32:0] cap;
        logic [32:0] e;
        exp_q.push_back(exp);
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {32'd0, req_ready}, 33'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 33'(k), 33'(2 + WAIT_CYCLES));
        e = exp_q.pop_front();
        cap = {rsp_err, rsp_rdata};
        chk("response", cap, e);
        if (hold > 0) begin
            req_valid  = 1'b1;
            req_write  = 1'b0;
            req_addr   = 8'($urandom);
            req_funct3 = 3'd2;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {32'd0, rsp_valid}, 33'd1);
            chk("hold_data", {rsp_err, rsp_rdata}, cap);
            chk("hold_req_ready", {32'd0, req_ready}, 33'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", {32'd0, rsp_valid}, 33'd0);
        chk("post_hs_data", {rsp_err, rsp_rdata}, 33'd0);
        chk("post_hs_ready", {32'd0, req_ready}, 33'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          hold;
    } vec_t;

    vec_t vecs[16];
    int   nv;

    task automatic add_vec(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [2:0] f3, input logic e_err, input logic [31:0] e_rd,
                           input int hold);
        vecs[nv].wr = wr;          vecs[nv].addr = addr;
        vecs[nv].wd = wd;          vecs[nv].f3 = f3;
        vecs[nv].exp_err = e_err;  vecs[nv].exp_rdata = e_rd;
        vecs[nv].hold = hold;
        nv++;
    endtask

    initial begin
        logic [32:0] res;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;

        nv = 0;
        add_vec(1, 8'h10, 32'hDEADBEEF, 3'd2, 0, 32'h00000000, 0);
        add_vec(0, 8'h10, 32'h0,        3'd2, 0, 32'hDEADBEEF, 0);
        add_vec(0, 8'h13, 32'h0,        3'd0, 0, 32'hFFFFFFDE, 0);
        add_vec(0, 8'h13, 32'h0,        3'd4, 0, 32'h000000DE, 0);
        add_vec(0, 8'h12, 32'h0,        3'd1, 0, 32'hFFFFDEAD, 0);
        add_vec(0, 8'h10, 32'h0,        3'd5, 0, 32'h0000BEEF, 0);
        add_vec(1, 8'h11, 32'h12345655, 3'd0, 0, 32'h00000000, 0);
        add_vec(0, 8'h10, 32'h0,        3'd2, 0, 32'hDEAD55EF, 5);
`ifdef DMEM_MISALIGN_ERR_EN
        add_vec(0, 8'h12, 32'h0,        3'd2, 1, 32'h00000000, 0);
`else
        add_vec(0, 8'h12, 32'h0,        3'd2, 0, 32'hDEAD55EF, 0);
`endif
        add_vec(0, 8'h10, 32'h0,        3'd3, 1, 32'h00000000, 0);
        add_vec(1, 8'h10, 32'hFFFFFFFF, 3'd4, 1, 32'h00000000, 0);
        add_vec(0, 8'h10, 32'h0,        3'd2, 0, 32'hDEAD55EF, 0);
        add_vec(0, 8'h11, 32'h0,        3'd0, 0, 32'h00000055, 0);
        add_vec(1, 8'h14, 32'h00000000, 3'd2, 0, 32'h00000000, 0);
        add_vec(1, 8'h16, 32'hAAAA7777, 3'd1, 0, 32'h00000000, 2);
        add_vec(0, 8'h14, 32'h0,        3'd2, 0, 32'h77770000, 0);

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("reset_rsp", {rsp_err, rsp_rdata}, 33'd0);
        chk("reset_valid", {32'd0, rsp_valid}, 33'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {32'd0, req_ready}, 33'd1);

        // ---- directed table ----
        for (int i = 0; i < nv; i++) begin
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].f3, res);
            send(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].f3,
                 {vecs[i].exp_err, vecs[i].exp_rdata}, vecs[i].hold);
        end

        // ---- reset in WAIT drops an in-flight store ----
        model_access(1'b1, 8'h20, 32'h11111111, 3'd2, res);
        send(1'b1, 8'h20, 32'h11111111, 3'd2, 33'd0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20;
        req_wdata = 32'hCAFEF00D; req_funct3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_rsp", {rsp_err, rsp_rdata}, 33'd0);
        chk("abort_valid", {32'd0, rsp_valid}, 33'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", {32'd0, req_ready}, 33'd1);
        send(1'b0, 8'h20, 32'h0, 3'd2, {1'b0, 32'h11111111}, 0);
        model_access(1'b0, 8'h20, 32'h0, 3'd2, res);
        chk("abort_model", res, {1'b0, 32'h11111111});

        // ---- random traffic against the reference memory ----
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            model_access(1'b1, 8'(w * 4), wd, 3'd2, res);
            send(1'b1, 8'(w * 4), wd, 3'd2, res, 0);
        end
        for (int i = 0; i < 150; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 8'($urandom);
            wd   = $urandom;
            f3   = 3'($urandom_range(0, 7));
            model_access(wr, addr, wd, f3, res);
            send(wr, addr, wd, f3, res, $urandom_range(0, 2));
        end

        chk("queue_empty", 33'(exp_q.size()), 33'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
